// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_SLICE = 32;

    function automatic int beats(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit two-level carry-lookahead adder built from 4-bit
// generate/propagate groups.
module cla_slice #(
    parameter int SLICE = 32
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             msb_a,
    output logic             msb_b
);
    localparam int NG = SLICE / 4;

    logic [SLICE-1:0] g, p, c;
    logic [NG-1:0]    gg, gp;
    logic [NG:0]      gc;
    logic             acc, pp;

    always_comb begin
        g   = a & b;
        p   = a ^ b;
        gg  = '0;
        gp  = '0;
        gc  = '0;
        c   = '0;
        acc = 1'b0;
        pp  = 1'b1;
        for (int i = 0; i < NG; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = &p[4*i +: 4];
        end
        // Group carries as flat sum-of-products over the group terms.
        gc[0] = cin;
        for (int i = 1; i <= NG; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & gg[j]);
                pp  = pp & gp[j];
            end
            gc[i] = acc | (pp & cin);
        end
        for (int i = 0; i < NG; i++) begin
            for (int k = 0; k < 4; k++) begin
                acc = 1'b0;
                pp  = 1'b1;
                for (int j = k - 1; j >= 0; j--) begin
                    acc = acc | (pp & g[4*i+j]);
                    pp  = pp & p[4*i+j];
                end
                c[4*i+k] = acc | (pp & gc[i]);
            end
        end
        sum  = p ^ c;
        cout = gc[NG];
    end

    assign msb_a = a[SLICE-1];
    assign msb_b = b[SLICE-1];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one shared CLA slice walked across
// WIDTH/SLICE beats with the carry chained through a register.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int BEATS = beats(WIDTH, SLICE);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((WIDTH % SLICE) != 0 || (SLICE % 4) != 0) begin : g_bad_params
        $error("mp_add_seq: WIDTH must be a multiple of SLICE and SLICE a multiple of 4");
    end

    state_t           state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry;
    logic [CW-1:0]    beat;
    logic [SLICE-1:0] sl_a, sl_b, sl_sum;
    logic             sl_cout, msb_a, msb_b, last;

    assign sl_a     = a_reg[beat*SLICE +: SLICE];
    assign sl_b     = b_reg[beat*SLICE +: SLICE];
    assign last     = (beat == CW'(BEATS - 1));
    assign in_ready = (state == IDLE);

    cla_slice #(.SLICE(SLICE)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (carry),
        .sum   (sl_sum),
        .cout  (sl_cout),
        .msb_a (msb_a),
        .msb_b (msb_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            beat      <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // Subtract is A + ~B + 1; B is inverted once at accept.
                    a_reg <= in_a;
                    b_reg <= in_sub ? ~in_b : in_b;
                    carry <= in_sub | in_cin;
                    beat  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    out_sum[beat*SLICE +: SLICE] <= sl_sum;
                    carry <= sl_cout;
                    beat  <= beat + 1'b1;
                    if (last) begin
                        out_cout  <= sl_cout;
                        // Carry into MSB xor carry out of MSB.
                        out_ovf   <= msb_a ^ msb_b ^ sl_sum[SLICE-1] ^ sl_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed and randomized checks for mp_add_seq against hand values and a
// full-width reference.
module tb_mp_add_seq;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_sub, in_cin;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0] out_sum;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mp_add_seq #(.WIDTH(W), .SLICE(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    // Drives one operation and returns the result; lat = -1 on timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input int hold,
                          output logic [W-1:0] s, output logic co,
                          output logic ov, output int lat);
        int t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = ~a; in_b = W'($urandom); in_sub = ~sub; in_cin = ~cin;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!out_valid) lat = -1;
        s = out_sum; co = out_cout; ov = out_ovf;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        in_cin = 1'b0; out_ready = 1'b0;
        #12;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_sum !== '0) begin n_bad++; $display("FAIL rst_out_sum: got %h want 0", out_sum); end
        n_cmp++; if (out_cout !== 1'b0) begin n_bad++; $display("FAIL rst_out_cout: got %b want 0", out_cout); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_out_ovf: got %b want 0", out_ovf); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, input logic cin, input logic [W-1:0] es,
                               input logic ec, input logic eo);
        logic [W-1:0] s; logic co, ov; int lat;
        run_op(a, b, sub, cin, 0, s, co, ov, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL %s_latency: got %0d want 4", name, lat); end
        n_cmp++; if (s !== es) begin n_bad++; $display("FAIL %s_sum: got %h want %h", name, s, es); end
        n_cmp++; if (co !== ec) begin n_bad++; $display("FAIL %s_cout: got %b want %b", name, co, ec); end
        n_cmp++; if (ov !== eo) begin n_bad++; $display("FAIL %s_ovf: got %b want %b", name, ov, eo); end
    endtask

    task automatic test_directed;
        test_vector("wrap", {W{1'b1}}, 128'd1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        test_vector("sub_neg", 128'd5, 128'd7, 1'b1, 1'b0, ~128'd1, 1'b0, 1'b0);
        test_vector("ovf", {1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
        test_vector("slice_cross", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
                    128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0);
        test_vector("add_cin", 128'd10, 128'd20, 1'b0, 1'b1, 128'd31, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        int t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        in_a = 128'd3; in_b = 128'd4; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
        n_cmp++; if (t !== 4) begin n_bad++; $display("FAIL bp_latency: got %0d want 4", t); end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; in_a = W'(1000 + i); in_b = W'(i); in_sub = 1'b0;
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, in_ready); end
            n_cmp++; if (out_sum !== 128'd7) begin n_bad++; $display("FAIL bp_hold_sum[%0d]: got %h want 7", i, out_sum); end
        end
        in_valid = 1'b1; in_a = 128'd100; in_b = 128'd1; in_sub = 1'b1; in_cin = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_no_same_cycle_accept: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_next_accept: got %b want 0", in_ready); end
        t = 0;
        while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
        n_cmp++; if (out_sum !== 128'd99) begin n_bad++; $display("FAIL bp_next_sum: got %h want 63", out_sum); end
        n_cmp++; if (out_cout !== 1'b1) begin n_bad++; $display("FAIL bp_next_cout: got %b want 1", out_cout); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL bp_next_ovf: got %b want 0", out_ovf); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort;
        int t = 0;
        in_a = {W{1'b1}}; in_b = 128'd1; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_run_ready: got %b want 1", in_ready); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_run_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_run_release_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_sum !== '0) begin n_bad++; $display("FAIL abort_run_sum: got %h want 0", out_sum); end
        in_a = 128'd9; in_b = 128'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL abort_done_reach: got %b want 1", out_valid); end
        #2; rst = 1'b1; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_done_async_valid: got %b want 0", out_valid); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_done_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, bp, es, s;
        logic         sub, cin, ec, eo, co, ov;
        int           lat, mode;
        for (int n = 0; n < 1000; n++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            mode = $urandom_range(0, 7);
            if (mode == 0) a = {W{1'b1}};
            if (mode == 1) b = {W{1'b1}};
            if (mode == 2) a = {1'b0, {(W-1){1'b1}}};
            if (mode == 3) b = '0;
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            bp  = sub ? ~b : b;
            {ec, es} = {1'b0, a} + {1'b0, bp} + (W+1)'(sub ? 1'b1 : cin);
            eo = (a[W-1] == bp[W-1]) && (es[W-1] != a[W-1]);
            run_op(a, b, sub, cin, $urandom_range(0, 3), s, co, ov, lat);
            n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want 4", n, lat); end
            n_cmp++; if (s !== es) begin n_bad++; $display("FAIL rnd_sum[%0d]: got %h want %h", n, s, es); end
            n_cmp++; if (co !== ec) begin n_bad++; $display("FAIL rnd_cout[%0d]: got %b want %b", n, co, ec); end
            n_cmp++; if (ov !== eo) begin n_bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", n, ov, eo); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add/subtract sequencer. It accepts two WIDTH-bit operands over a valid/ready handshake and time-multiplexes a single SLICE-bit carry-lookahead slice across WIDTH/SLICE beats, chaining the carry through a register. It presents the full result, carry-out and signed overflow on an output valid/ready handshake. It sits between the operand source and any consumer needing wide adds, where a full-width combinational CLA is too large or too slow.

## Interface
- WIDTH, 128: operand/result width; multiple of SLICE.
- SLICE, 32: width of the shared CLA slice; multiple of 4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept; high only in IDLE.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1 = A − B (B inverted, carry-in forced 1); 0 = A + B + in_cin.
- in_cin  in  1  carry-in for add; ignored when in_sub=1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry out of MSB; on subtract, 1 = no borrow.
- out_ovf  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch A.
  - latch B, or ~B when in_sub=1.
  - carry register <= in_sub ? 1 : in_cin.
  - beat counter <= 0.
  - go to RUN.
- RUN: each cycle the slice adds A[k*SLICE +: SLICE], B'[k*SLICE +: SLICE] and the carry register.
  - Slice sum is written to sum[k*SLICE +: SLICE].
  - Carry register <= slice carry-out.
  - k increments.
  - After beat k = BEATS−1, go to DONE.
- DONE: out_valid=1, with out_sum, out_cout and out_ovf stable.
  - On out_ready, return to IDLE.
  - Output registers keep their values until the next result is written.
- out_ovf = A[MSB] ^ B'[MSB] ^ sum[MSB] ^ cout, i.e. carry-into-MSB xor carry-out. It is computed on the final beat.
- in_valid while not in IDLE is ignored. Inputs are sampled only on the accept edge, so changes afterwards have no effect.
- No simultaneous accept/return: in DONE with out_ready=1, in_ready stays 0 that cycle, and a new request is taken at the earliest one cycle later.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 1, because the state is IDLE.
  - out_valid = 0.
  - out_sum = 0, out_cout = 0, out_ovf = 0.
  - carry register and beat counter = 0.
- Latency: accept at edge T means out_valid is high after edge T+BEATS. With the defaults that is 4 cycles.
- Throughput: one operation per BEATS+2 cycles when out_ready is held high.
- out_valid is a registered output and does not depend combinationally on out_ready. in_ready is decoded from the state register only.
- Reset asserted mid-RUN or in DONE aborts the operation immediately:
  - out_valid drops asynchronously.
  - The partial result is discarded.
  - in_ready=1 on the first edge after rst deasserts.
- Critical path is one SLICE-bit CLA plus mux and register. It is independent of WIDTH.

## Structure
- Package mp_add_pkg holds:
  - the state enum (IDLE/RUN/DONE).
  - default SLICE.
  - a BEATS = WIDTH/SLICE constant function.
- One sub-module, cla_slice: combinational SLICE-bit two-level carry-lookahead adder built from 4-bit generate/propagate groups. Ports: a, b, cin, sum, cout, msb_a, msb_b.
- The sequencer owns the FSM, beat counter, operand registers, carry register and result registers.
- Elaboration-time check: WIDTH % SLICE == 0 and SLICE % 4 == 0.

## Test plan
- A=all-ones(128), B=1, add, cin=0 -> out_sum=0, out_cout=1, out_ovf=0. out_valid high exactly 4 cycles after accept.
- A=5, B=7, sub -> out_sum=0xFFFF…FFFE, out_cout=0, out_ovf=0.
- A=0x7FFF…FFFF, B=1, add -> out_sum=0x8000…0000, out_cout=0, out_ovf=1.
- A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1, add -> carry crosses the slice boundary; out_sum=0x…0001_0000_0000.
- out_ready held low 10 cycles in DONE while in_valid pulses with new operands:
  - outputs stay stable and in_ready stays 0.
  - the new request is not taken.
  - after out_ready, the next request is accepted and computed correctly.
- rst pulsed at beat 2 of an add:
  - out_valid=0 and in_ready=1 after release.
  - a following 1000-operation random add/sub run with random backpressure matches a full-width reference model, including cout and ovf.
